// File: rtl/sram_ctrl_pkg.sv
// +-----------------------------------------------------------------------+
// | sram_ctrl_pkg : shared constants and FSM encoding for the SRAM reader |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package sram_ctrl_pkg;

  localparam int MACRO_WIDTH        = 32;
  localparam int RD_LATENCY_DEFAULT = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
// +-----------------------------------------------------------------------+
// | sync_fifo_fwft : first-word fall-through synchronous FIFO             |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module sync_fifo_fwft #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int                 PTR_BIT  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                 CNT_BIT  = $clog2(DEPTH + 1);
  localparam logic [PTR_BIT-1:0] PTR_LAST = PTR_BIT'(DEPTH - 1);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_BIT-1:0] wptr_q;
  logic [PTR_BIT-1:0] rptr_q;
  logic [CNT_BIT-1:0] count_q;
  logic               do_push;
  logic               do_pop;

  assign full    = (count_q == CNT_BIT'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_pop  = pop && !empty;
  // A full FIFO may still accept a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_BIT'(1);
      end
      if (do_pop) begin
        rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_BIT'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_BIT'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CNT_BIT'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_burst_reader.sv
// +-----------------------------------------------------------------------+
// | sram_burst_reader : burst-read / single-write controller for one      |
// | SRAM port, credit-protected return FIFO, valid/ready read stream      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module sram_burst_reader
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_BIT   = 128,
  parameter int DEPTH      = 128,
  parameter int ADDR_BIT   = $clog2(DEPTH),
  parameter int RD_LATENCY = RD_LATENCY_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_BIT    = ADDR_BIT + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_BIT-1:0] cmd_addr,
  input  logic [LEN_BIT-1:0]  cmd_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_BIT-1:0] wr_addr,
  input  logic [DATA_BIT-1:0] wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_BIT-1:0] rd_data,
  output logic                rd_last,
  output logic                burst_done,
  output logic [ADDR_BIT-1:0] sram_addr,
  output logic                sram_wen,
  output logic [DATA_BIT-1:0] sram_wdata,
  output logic                sram_ren,
  input  logic [DATA_BIT-1:0] sram_rdata
);

  localparam int                  CNT_BIT   = $clog2(FIFO_DEPTH + 1);
  localparam int                  CRD_BIT   = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
  localparam int                  BANKS     = DATA_BIT / MACRO_WIDTH;
  localparam logic [ADDR_BIT-1:0] ADDR_LAST = ADDR_BIT'(DEPTH - 1);

  burst_state_e        state_q, state_d;
  logic [ADDR_BIT-1:0] addr_q, addr_d;
  logic [LEN_BIT-1:0]  remain_q, remain_d;
  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY-1:0] pipe_last_q, pipe_last_d;
  logic                zero_done_q;

  logic                wr_go;
  logic                rd_go;
  logic                cmd_go;
  logic                pop;
  logic                last_pop;
  logic                credit_ok;
  logic [CRD_BIT-1:0]  inflight;

  logic                fifo_push;
  logic [DATA_BIT:0]   fifo_wdata;
  logic [DATA_BIT:0]   fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_BIT-1:0]  fifo_count;

  // Slot arbitration: a write always wins, a read needs a free FIFO credit
  assign wr_ready  = !rst;
  assign wr_go     = wr_valid && !rst;
  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign cmd_go    = cmd_valid && cmd_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CRD_BIT'(pipe_vld_q[i]);
    end
  end

  assign credit_ok = (CRD_BIT'(fifo_count) + inflight) < CRD_BIT'(FIFO_DEPTH);
  assign rd_go     = (state_q == ST_BURST) && (remain_q != '0) && !wr_go
                     && credit_ok && !rst;

  assign rd_valid   = !fifo_empty && !rst;
  assign rd_data    = fifo_rdata[DATA_BIT-1:0];
  assign rd_last    = fifo_rdata[DATA_BIT] && rd_valid;
  assign pop        = rd_valid && rd_ready;
  assign last_pop   = pop && rd_last;
  assign burst_done = !rst && (zero_done_q || ((state_q == ST_BURST) && last_pop));

  assign sram_wen  = wr_go;
  assign sram_addr = wr_go ? wr_addr : (rd_go ? addr_q : '0);
  assign sram_ren  = pipe_vld_q[0] && !rst;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign sram_wdata[b*MACRO_WIDTH +: MACRO_WIDTH] =
      wr_go ? wr_data[b*MACRO_WIDTH +: MACRO_WIDTH] : '0;
  end

  // Shift in at bit 0; the oldest read sits at bit RD_LATENCY-1
  assign pipe_vld_d  = RD_LATENCY'({pipe_vld_q, rd_go});
  assign pipe_last_d = RD_LATENCY'({pipe_last_q, rd_go && (remain_q == LEN_BIT'(1))});

  assign fifo_push  = pipe_vld_q[RD_LATENCY-1];
  assign fifo_wdata = {pipe_last_q[RD_LATENCY-1], sram_rdata};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_go && (cmd_len != '0)) begin
          state_d  = ST_BURST;
          addr_d   = cmd_addr;
          remain_d = cmd_len;
        end
      end
      ST_BURST: begin
        if (rd_go) begin
          addr_d   = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_BIT'(1);
          remain_d = remain_q - LEN_BIT'(1);
        end
        if (last_pop) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      zero_done_q <= cmd_go && (cmd_len == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_push && fifo_full && !pop))
        else $error("sram_burst_reader: return FIFO overflow");
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_BIT + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_ret_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

`default_nettype wire
